legv8_datapath_ts: RTL and testbench

// - LEGv8 64-bit datapath on a shared tri-state data bus, driven by a 40-bit microcode control word.
// - Contains a 32x64 register file, ALU, a 128x64 data RAM, PC, IR and a status register.
// - Sits between the control unit (ControlWord, IR_out, current_status) and external instruction memory/IO (data, address).

---
 rtl/legv8_datapath_ts.sv | 164 ++++++++++++++++
 tb/tb_legv8_datapath_ts.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_datapath_ts.sv
// ============================================================================
// Module      : legv8_datapath_ts
// Description : LEGv8 64-bit datapath (register file, ALU, data RAM, PC, IR,
//               status) sharing one tri-state data bus, steered by a 40-bit
//               microcode control word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module legv8_datapath_ts #(
    parameter int RAM_WORDS = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [39:0] ControlWord,
    inout  wire  [63:0] data,
    output logic [31:0] address,
    input  logic [63:0] constant,
    output logic [4:0]  status,
    output logic [31:0] IR_out,
    output logic [3:0]  current_status,
    output logic [15:0] r0,
    output logic [15:0] r1,
    output logic [15:0] r2,
    output logic [15:0] r3,
    output logic [15:0] r4,
    output logic [15:0] r5,
    output logic [15:0] r6,
    output logic [15:0] r7
);

    localparam int c_IDX_W = $clog2(RAM_WORDS);

    // ---------------- control word fields ----------------
    logic [4:0] w_sb, w_sa, w_da, w_fs;
    logic       w_rw, w_mw, w_c0, w_sl, w_bs, w_il, w_as;
    logic [1:0] w_ps, w_ds;
    logic       w_unused_cw;

    assign w_sb = ControlWord[4:0];
    assign w_sa = ControlWord[9:5];
    assign w_da = ControlWord[14:10];
    assign w_rw = ControlWord[15];
    assign w_mw = ControlWord[16];
    assign w_c0 = ControlWord[19];
    assign w_fs = ControlWord[24:20];
    assign w_sl = ControlWord[25];
    assign w_bs = ControlWord[26];
    assign w_il = ControlWord[27];
    assign w_as = ControlWord[28];
    assign w_ps = ControlWord[30:29];
    assign w_ds = ControlWord[32:31];
    // Size field and control-unit-only bits have no effect here.
    assign w_unused_cw = ^{ControlWord[39:33], ControlWord[18:17]};

    // ---------------- state ----------------
    logic [63:0] r_x_q [0:31];
    logic [63:0] r_ram_q [0:RAM_WORDS-1];
    logic [63:0] r_pc_q, w_pc_d;
    logic [31:0] r_ir_q, w_ir_d;
    logic [3:0]  r_cs_q, w_cs_d;

    // ---------------- register file read ----------------
    logic [63:0] w_a, w_b;
    assign w_a = (w_sa == 5'd31) ? 64'd0 : r_x_q[w_sa];
    assign w_b = (w_sb == 5'd31) ? 64'd0 : r_x_q[w_sb];

    // ---------------- ALU ----------------
    logic [63:0] w_ap, w_bm, w_bp, w_f;
    logic [64:0] w_sum;
    logic        w_c, w_v, w_n, w_z;

    always_comb begin
        w_ap  = w_fs[1] ? ~w_a : w_a;
        w_bm  = w_bs ? constant : w_b;
        w_bp  = w_fs[0] ? ~w_bm : w_bm;
        w_sum = {1'b0, w_ap} + {1'b0, w_bp} + {64'd0, w_c0};
        w_f   = 64'd0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (w_fs[4:2])
            3'b000: w_f = w_ap & w_bp;
            3'b001: w_f = w_ap | w_bp;
            3'b010: begin
                w_f = w_sum[63:0];
                w_c = w_sum[64];
                w_v = (w_ap[63] == w_bp[63]) && (w_sum[63] != w_ap[63]);
            end
            3'b011: w_f = w_ap ^ w_bp;
            3'b100: w_f = w_ap << w_bm[5:0];
            3'b101: w_f = w_ap >> w_bm[5:0];
            default: w_f = 64'd0;
        endcase
        w_n = w_f[63];
        w_z = (w_f == 64'd0);
    end

    assign status  = {(w_b == 64'd0), w_v, w_c, w_n, w_z};
    assign address = w_as ? r_pc_q[31:0] : w_f[31:0];

    // ---------------- bus ----------------
    logic [c_IDX_W-1:0] w_ram_idx;
    logic [63:0]        w_bus_out;
    assign w_ram_idx = address[3 +: c_IDX_W];

    always_comb begin
        w_bus_out = w_f;
        case (w_ds)
            2'b01:   w_bus_out = w_b;
            2'b11:   w_bus_out = r_ram_q[w_ram_idx];
            default: w_bus_out = w_f;
        endcase
    end

    // DS=10 leaves the bus to an external agent (instruction fetch / input).
    assign data = (w_ds != 2'b10) ? w_bus_out : 64'bz;

    // ---------------- next-state ----------------
    always_comb begin
        w_pc_d = r_pc_q;
        case (w_ps)
            2'b01:   w_pc_d = r_pc_q + 64'd4;
            2'b10:   w_pc_d = data;
            2'b11:   w_pc_d = r_pc_q + data;
            default: w_pc_d = r_pc_q;
        endcase
        w_ir_d = w_il ? data[31:0] : r_ir_q;
        w_cs_d = w_sl ? {w_v, w_c, w_n, w_z} : r_cs_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc_q <= 64'd0;
            r_ir_q <= 32'd0;
            r_cs_q <= 4'd0;
            for (int i = 0; i < 32; i++) r_x_q[i] <= 64'd0;
        end else begin
            r_pc_q <= w_pc_d;
            r_ir_q <= w_ir_d;
            r_cs_q <= w_cs_d;
            if (w_rw && (w_da != 5'd31)) r_x_q[w_da] <= data;
        end
    end

    // RAM keeps its contents across reset but accepts no writes during it.
    always_ff @(posedge clock) begin
        if (reset && w_mw) r_ram_q[w_ram_idx] <= data;
    end

    // ---------------- outputs ----------------
    assign IR_out         = r_ir_q;
    assign current_status = r_cs_q;
    assign r0 = r_x_q[0][15:0];
    assign r1 = r_x_q[1][15:0];
    assign r2 = r_x_q[2][15:0];
    assign r3 = r_x_q[3][15:0];
    assign r4 = r_x_q[4][15:0];
    assign r5 = r_x_q[5][15:0];
    assign r6 = r_x_q[6][15:0];
    assign r7 = r_x_q[7][15:0];

endmodule

`default_nettype wire

// File: tb/tb_legv8_datapath_ts.sv
// ============================================================================
// Module      : tb_legv8_datapath_ts
// Description : Scoreboard bench for legv8_datapath_ts with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_legv8_datapath_ts;

    logic        clock = 1'b0;
    logic        reset;
    logic [39:0] cw;
    logic [63:0] konst;
    logic        tb_en;
    logic [63:0] tb_val;
    wire  [63:0] data;
    logic [31:0] address;
    logic [4:0]  status;
    logic [31:0] IR_out;
    logic [3:0]  current_status;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

    always #5 clock = ~clock;
    assign data = tb_en ? tb_val : 64'bz;

    legv8_datapath_ts #(.RAM_WORDS(128)) dut (
        .clock(clock), .reset(reset), .ControlWord(cw), .data(data),
        .address(address), .constant(konst), .status(status), .IR_out(IR_out),
        .current_status(current_status),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7)
    );

    typedef struct packed {
        logic [4:0]   st;
        logic [31:0]  addr;
        logic [63:0]  bus;
        logic [31:0]  ir;
        logic [3:0]   cs;
        logic [127:0] rr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    logic [63:0] mx   [32];
    logic [63:0] mram [128];
    logic [63:0] mpc;
    logic [31:0] mir;
    logic [3:0]  mcs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [39:0] mk(input int sb, input int sa, input int da,
                                       input bit rw, input bit mw, input bit c0,
                                       input int fs, input bit sl, input bit bs,
                                       input bit il, input bit as_, input int ps,
                                       input int ds);
        logic [39:0] w;
        w = '0;
        w[4:0]   = sb[4:0];
        w[9:5]   = sa[4:0];
        w[14:10] = da[4:0];
        w[15]    = rw;
        w[16]    = mw;
        w[18:17] = 2'b11;
        w[19]    = c0;
        w[24:20] = fs[4:0];
        w[25]    = sl;
        w[26]    = bs;
        w[27]    = il;
        w[28]    = as_;
        w[30:29] = ps[1:0];
        w[32:31] = ds[1:0];
        return w;
    endfunction

    // Apply one cycle of stimulus, record what the DUT should show, then
    // advance the model across the coming clock edge.
    task automatic issue(input logic [39:0] w, input logic [63:0] k,
                         input logic [63:0] ext, input bit rst_low);
        int          sa, sb, da, fs;
        logic [63:0] a, b, bm, ap, bp, f, bus;
        logic [64:0] usum;
        logic signed [65:0] ssum;
        logic        c, v;
        logic [31:0] addr;
        int          idx;
        exp_t        e;

        reset  = !rst_low;
        cw     = w;
        konst  = k;
        tb_en  = (w[32:31] == 2'b10);
        tb_val = ext;
        if (rst_low) begin
            for (int i = 0; i < 32; i++) mx[i] = 64'd0;
            mpc = 64'd0; mir = 32'd0; mcs = 4'd0;
        end

        sb = int'(w[4:0]); sa = int'(w[9:5]); da = int'(w[14:10]); fs = int'(w[24:20]);
        a  = (sa == 31) ? 64'd0 : mx[sa];
        b  = (sb == 31) ? 64'd0 : mx[sb];
        bm = w[26] ? k : b;
        ap = (fs & 2) != 0 ? ~a : a;
        bp = (fs & 1) != 0 ? ~bm : bm;
        c = 1'b0; v = 1'b0;
        case (fs / 4)
            0: f = ap & bp;
            1: f = ap | bp;
            2: begin
                usum = 65'(ap) + 65'(bp) + 65'(w[19]);
                f    = usum[63:0];
                c    = usum[64];
                ssum = 66'($signed(ap)) + 66'($signed(bp)) + 66'(w[19]);
                v    = (ssum > 66'sd9223372036854775807) || (ssum < -66'sd9223372036854775808);
            end
            3: f = ap ^ bp;
            4: f = ap << int'(bm[5:0]);
            5: f = ap >> int'(bm[5:0]);
            default: f = 64'd0;
        endcase

        addr = w[28] ? mpc[31:0] : f[31:0];
        idx  = int'(addr[9:3]);
        case (w[32:31])
            2'b00: bus = f;
            2'b01: bus = b;
            2'b10: bus = ext;
            default: bus = mram[idx];
        endcase

        e.st   = {(b == 64'd0), v, c, f[63], (f == 64'd0)};
        e.addr = addr;
        e.bus  = bus;
        e.ir   = mir;
        e.cs   = mcs;
        for (int i = 0; i < 8; i++) e.rr[16*i +: 16] = mx[i][15:0];
        q.push_back(e);

        if (!rst_low) begin
            if (w[15] && da != 31) mx[da] = bus;
            if (w[16]) mram[idx] = bus;
            case (w[30:29])
                2'b01: mpc = mpc + 64'd4;
                2'b10: mpc = bus;
                2'b11: mpc = mpc + bus;
                default: ;
            endcase
            if (w[27]) mir = bus[31:0];
            if (w[25]) mcs = {v, c, f[63], (f == 64'd0)};
        end
    endtask

    // monitor: the DUT presents a settled result every cycle at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("status", 64'(status), 64'(e.st));
                chk("address", 64'(address), 64'(e.addr));
                chk("data_bus", data, e.bus);
                chk("IR_out", 64'(IR_out), 64'(e.ir));
                chk("current_status", 64'(current_status), 64'(e.cs));
                chk("r0_r3", {r3, r2, r1, r0}, e.rr[63:0]);
                chk("r4_r7", {r7, r6, r5, r4}, e.rr[127:64]);
            end
        end
    end

    initial begin
        logic [63:0] rnd;
        reset = 1'b0; cw = '0; konst = '0; tb_en = 1'b0; tb_val = '0;
        for (int i = 0; i < 32; i++) mx[i] = 64'd0;
        mpc = 0; mir = 0; mcs = 0;

        tick(); issue(mk(0,0,0,0,0,0,0,0,0,0,0,0,0), 64'd0, 64'd0, 1'b1);
        tick(); issue(mk(0,0,0,0,0,0,0,0,0,0,0,0,0), 64'd0, 64'd0, 1'b1);

        // fill RAM so every word is known: RAM[i] = i*8
        for (int i = 0; i < 128; i++) begin
            tick(); issue(mk(0,31,0,0,1,0,8,0,1,0,0,0,0), 64'(i*8), 64'd0, 1'b0);
        end

        tick(); issue(mk(0,31,0,1,0,0,5'b00100,0,1,0,0,0,0), 64'd24, 64'd0, 1'b0);
        tick(); chk("spec_r0", 64'(r0), 64'h0018);
        issue(mk(0,31,1,1,0,1,5'b01001,1,0,0,0,0,0), 64'd0, 64'd0, 1'b0);
        tick(); chk("spec_r1_neg", 64'(r1), 64'hFFE8);
        chk("spec_cs_N", 64'(current_status), 64'b0010);
        issue(mk(1,31,0,0,1,0,5'b01000,0,1,0,0,0,1), 64'd24, 64'd0, 1'b0);
        #1 chk("spec_store_addr", 64'(address), 64'd24);
        tick(); issue(mk(1,0,1,1,0,0,5'b00000,0,0,0,0,0,0), 64'd0, 64'd0, 1'b0);
        tick(); chk("spec_and", 64'(r1), 64'h0008);
        issue(mk(0,31,2,1,0,0,5'b01000,0,1,0,0,0,3), 64'd24, 64'd0, 1'b0);
        tick(); chk("spec_load", 64'(r2), 64'hFFE8);
        issue(mk(0,0,0,0,0,0,0,0,0,1,1,0,2), 64'd0, 64'h8B020020, 1'b0);
        #1 chk("spec_fetch_addr", 64'(address), 64'd0);
        tick(); chk("spec_ir", 64'(IR_out), 64'h8B020020);
        issue(mk(0,0,0,0,0,0,0,0,0,0,1,1,0), 64'd0, 64'd0, 1'b0);
        tick(); issue(mk(0,0,0,0,0,0,0,0,0,0,1,1,0), 64'd0, 64'd0, 1'b0);
        tick(); issue(mk(0,0,0,0,0,0,0,0,0,0,1,2,2), 64'd0, 64'h100, 1'b0);
        #1 chk("spec_pc8", 64'(address), 64'd8);
        tick(); issue(mk(0,0,0,0,0,0,0,0,0,0,1,0,2), 64'd0, 64'd0, 1'b0);
        #1 chk("spec_pc_load", 64'(address), 64'h100);
        tick(); issue(mk(0,0,0,0,0,0,0,0,0,0,1,1,2), 64'd0, 64'd0, 1'b1);
        #1 chk("spec_reset_pc", 64'(address), 64'd0);
        chk("spec_reset_ir", 64'(IR_out), 64'd0);

        for (int n = 0; n < 600; n++) begin
            rnd = {$urandom, $urandom};
            tick();
            issue(rnd[39:0], {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 39) == 0));
        end

        tick(); issue(mk(0,0,0,0,0,0,0,0,0,0,0,0,0), 64'd0, 64'd0, 1'b0);
        repeat (3) tick();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
